// File: rtl/mmio_io_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_io_ctrl
//   Memory-mapped I/O block for a small CPU: a button status register at
//   0xFB and four 7-segment digit registers at 0xFC..0xFF.  The block
//   debounces three push buttons and multiplexes the four digits onto a
//   shared segment bus.
//
//   CPU access: there is no valid/ready handshake.  'we' is a single-cycle
//   store strobe that is committed at the rising clk edge where it is high.
//   Reads are purely combinational from 'addr' with zero wait states.  'hit'
//   tells the data memory to stay out of the access for 0xFB..0xFF.
//
// Ports
//   clk    in   1  clock, all state on the rising edge
//   rst    in   1  synchronous active-high reset
//   addr   in   8  CPU data address
//   wdata  in   8  CPU store data
//   we     in   1  CPU store strobe (one cycle per store)
//   hit    out  1  addr is in the I/O window 0xFB..0xFF
//   rdata  out  8  read data for I/O addresses (0 elsewhere)
//   btn    in   3  raw asynchronous buttons: [0] center, [1] left, [2] right
//   seg    out  8  active-low segments of the digit being scanned
//   an     out  4  active-low digit enables, an[3] leftmost
// ---------------------------------------------------------------------------
module mmio_io_ctrl #(
    parameter logic [15:0] DB_CYCLES   = 16'd20000,
    parameter logic [15:0] SCAN_CYCLES = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       we,
    output logic       hit,
    output logic [7:0] rdata,
    input  logic [2:0] btn,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam logic [15:0] DB_LAST   = DB_CYCLES - 16'd1;
    localparam logic [15:0] SCAN_LAST = SCAN_CYCLES - 16'd1;

    logic [7:0]  digit [4];
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  btn_stable;
    logic [15:0] db_cnt [3];
    logic [15:0] scan_cnt;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic        scan_wrap;
    logic        digit_sel;

    // ---------------- address decode and read path ----------------
    assign hit       = (addr >= 8'hFB);
    // 0xFC..0xFF map straight onto addr[1:0] = digit number.
    assign digit_sel = (addr >= 8'hFC);

    always_comb begin
        rdata = 8'h00;
        if (addr == 8'hFB) begin
            rdata = {5'b00000, btn_stable};
        end else if (digit_sel) begin
            rdata = digit[addr[1:0]];
        end
    end

    // ---------------- digit registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                digit[i] <= 8'hFF;
            end
        end else if (we && digit_sel) begin
            digit[addr[1:0]] <= wdata;
        end
    end

    // ---------------- button synchronizer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // ---------------- debounce ----------------
    // A counter only runs while the synchronized input disagrees with the
    // accepted level; any return to agreement (a glitch) zeroes it, so a
    // change must persist for DB_CYCLES consecutive cycles to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_stable <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == btn_stable[i]) begin
                    db_cnt[i] <= 16'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_stable[i] <= sync2[i];
                    db_cnt[i]     <= 16'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    // ---------------- display scan ----------------
    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign idx_next  = scan_wrap ? (idx + 2'd1) : idx;

    // 'an' is registered from idx_next so it always matches idx exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= 16'd0;
            idx      <= 2'd0;
            an       <= 4'b1110;
        end else begin
            scan_cnt <= scan_wrap ? 16'd0 : (scan_cnt + 16'd1);
            idx      <= idx_next;
            an       <= ~(4'b0001 << idx_next);
        end
    end

    // Combinational so a store to the visible digit shows the next cycle.
    assign seg = digit[idx];

endmodule
